mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one synchronous memory port (12-bit address, 8-bit data) between several bus masters: the CPU core, a DMA/loader engine and other peripherals. Rotating-priority arbitration, one transaction per grant. Optional lock lets a master run back-to-back accesses up to MAX_HOLD. Sits between the masters and the RAM/ROM; the memory side uses split data buses with no tristate.

Parameters:
REQUESTERS, 2, number of masters (1..8)
ADDR_WIDTH, 12, address width
DATA_WIDTH, 8, data width
MAX_HOLD, 4, max consecutive transactions per locked grant (>=1)

Ports:
clock  input  1  rising-edge clock
resetN  input  1  asynchronous active-low reset
req  input  REQUESTERS  per-master request; hold until ack
lock  input  REQUESTERS  per-master keep-grant request
reqWrite  input  REQUESTERS  1 = write, 0 = read
reqAddr  input  REQUESTERS*ADDR_WIDTH  packed addresses; master i at [i*AW +: AW]
reqWdata  input  REQUESTERS*DATA_WIDTH  packed write data
grant  output  REQUESTERS  one-hot current owner
ack  output  REQUESTERS  one-cycle completion pulse
rdata  output  DATA_WIDTH  read data, valid while ack is high
busy  output  1  high when the state is not IDLE
memValid  output  1  memory strobe, one cycle per access
memWrite  output  1  write enable, qualified by memValid
memAddr  output  ADDR_WIDTH  memory address
memWdata  output  DATA_WIDTH  memory write data
memRdata  input  DATA_WIDTH  memory read data, valid the cycle after memValid

Behaviour:
- Reset (resetN low, async): state IDLE. grant, ack, busy, memValid and memWrite are 0. memAddr, memWdata and rdata are 0. Round-robin pointer last = REQUESTERS-1. holdCount = 0.
- Reset mid-transaction aborts it. No ack is issued. The master must re-request.
- FSM has states IDLE, ISSUE and DONE. All outputs are registered.
- IDLE: at the edge where any req is high:
  - winner = first requesting index scanning last+1, last+2, ... modulo REQUESTERS.
  - Register grant, memAddr, memWdata and memWrite from the winner.
  - memValid <= 1. last <= winner. holdCount <= 1. Go to ISSUE.
- ISSUE: lasts exactly one cycle, with memValid high. Next edge: memValid <= 0, memWrite <= 0.
  - ack[winner] <= 1.
  - rdata <= memRdata on a read. On a write, rdata holds its previous value.
  - Go to DONE.
- DONE: lasts exactly one cycle, with ack high. Next edge: ack <= 0.
  - If lock[winner] and req[winner] are high and holdCount < MAX_HOLD: reissue for the same winner, resampling its addr, data and write. memValid <= 1, holdCount+1, go to ISSUE, grant stays.
  - Otherwise grant <= 0 and go to IDLE.
- Latency: req sampled at edge E. memValid is high E..E+1 and ack is high E+1..E+2. A locked repeat is 2 cycles per access; an unlocked access is 3 cycles request-to-request.
- Masters keep req, reqAddr, reqWdata and reqWrite stable until ack.
  - A master that drops req before ack still gets its transaction completed and acked.
  - A req still high at the first IDLE sample after ack counts as a new request.
- Simultaneous requests are resolved by rotation only. Each master waits at most REQUESTERS-1 unlocked grants.
- lock is ignored once holdCount reaches MAX_HOLD. The grant is then released and the other masters are arbitrated normally.
- memAddr and memWdata hold their last values between accesses.
- ack and grant are never high for more than one master.

Test Plan:
- Reset: resetN=0 mid-ISSUE with master 0 at addr 0x123 -> all outputs 0 immediately, no ack[0]. After release with req idle -> IDLE, busy=0.
- Single read: master 0 reads addr 0x0A5, memory returns 0x3C -> memValid for one cycle with memAddr=0x0A5, memWrite=0; ack[0] on the next cycle with rdata=0x3C.
- Single write: master 1 writes 0x7E to 0xFFF -> memValid=1, memWrite=1, memAddr=0xFFF, memWdata=0x7E for one cycle; ack[1] one cycle later; rdata unchanged.
- Contention: masters 0 and 1 both request continuously after reset -> grants alternate 0,1,0,1; each unlocked access takes 3 cycles; ack never overlaps.
- Lock limit: MAX_HOLD=4, master 1 holds req+lock for 6 accesses while master 0 also requests -> 4 back-to-back master-1 accesses (2 cycles each), then master 0 is served, then master 1 resumes.
- Early drop: master 0 drops req one cycle after it is sampled -> transaction still completes, ack[0] pulses once, FSM returns to IDLE with no new grant.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Rotating-priority arbiter sharing one synchronous memory port among bus masters.
// One access per grant; a locked master may chain up to MAX_HOLD back-to-back accesses.
module mem_bus_arbiter #(
    parameter int unsigned REQUESTERS = 2,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_HOLD   = 4
) (
    input  logic                             clock,
    input  logic                             resetN,
    input  logic [REQUESTERS-1:0]            req,
    input  logic [REQUESTERS-1:0]            lock,
    input  logic [REQUESTERS-1:0]            reqWrite,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] reqAddr,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] reqWdata,
    output logic [REQUESTERS-1:0]            grant,
    output logic [REQUESTERS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic                             memValid,
    output logic                             memWrite,
    output logic [ADDR_WIDTH-1:0]            memAddr,
    output logic [DATA_WIDTH-1:0]            memWdata,
    input  logic [DATA_WIDTH-1:0]            memRdata
);

    localparam int unsigned PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state_q, state_n;
    logic [PW-1:0]         last_idx, last_n;
    logic [HW-1:0]         hold_q, hold_n;
    logic [REQUESTERS-1:0] grant_n, ack_n;
    logic [DATA_WIDTH-1:0] rdata_n, mem_wdata_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic                  mem_valid_n, mem_write_n;
    logic [PW-1:0]         win, cand;

    logic [ADDR_WIDTH-1:0] addr_arr  [REQUESTERS];
    logic [DATA_WIDTH-1:0] wdata_arr [REQUESTERS];

    for (genvar g = 0; g < int'(REQUESTERS); g++) begin : g_unpack
        assign addr_arr[g]  = reqAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = reqWdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the farthest offset down so the nearest requester after last_idx wins.
    always_comb begin
        win  = last_idx;
        cand = '0;
        for (int k = int'(REQUESTERS); k >= 1; k--) begin
            cand = PW'((int'(last_idx) + k) % int'(REQUESTERS));
            if (req[cand]) begin
                win = cand;
            end
        end
    end

    always_comb begin
        state_n     = state_q;
        last_n      = last_idx;
        hold_n      = hold_q;
        grant_n     = grant;
        ack_n       = '0;
        rdata_n     = rdata;
        mem_valid_n = 1'b0;
        mem_write_n = memWrite;
        mem_addr_n  = memAddr;
        mem_wdata_n = memWdata;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_n     = REQUESTERS'(1) << win;
                    mem_addr_n  = addr_arr[win];
                    mem_wdata_n = wdata_arr[win];
                    mem_write_n = reqWrite[win];
                    mem_valid_n = 1'b1;
                    last_n      = win;
                    hold_n      = HW'(1);
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                mem_write_n = 1'b0;
                ack_n       = REQUESTERS'(1) << last_idx;
                if (!memWrite) begin
                    rdata_n = memRdata;
                end
                state_n = DONE;
            end
            DONE: begin
                // Locked owner reissues with freshly sampled request fields until the hold budget runs out.
                if (lock[last_idx] && req[last_idx] && (hold_q < HW'(MAX_HOLD))) begin
                    mem_addr_n  = addr_arr[last_idx];
                    mem_wdata_n = wdata_arr[last_idx];
                    mem_write_n = reqWrite[last_idx];
                    mem_valid_n = 1'b1;
                    hold_n      = hold_q + HW'(1);
                    state_n     = ISSUE;
                end else begin
                    grant_n = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                grant_n     = '0;
                mem_write_n = 1'b0;
                state_n     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            last_idx <= PW'(REQUESTERS - 1);
            hold_q   <= '0;
            grant    <= '0;
            ack      <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            memValid <= 1'b0;
            memWrite <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
        end else begin
            state_q  <= state_n;
            last_idx <= last_n;
            hold_q   <= hold_n;
            grant    <= grant_n;
            ack      <= ack_n;
            rdata    <= rdata_n;
            busy     <= (state_n != IDLE);
            memValid <= mem_valid_n;
            memWrite <= mem_write_n;
            memAddr  <= mem_addr_n;
            memWdata <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of single accesses plus contention, lock-limit,
// early-drop and reset sequences, checked by a scoreboard on the memory/ack side.
module tb_mem_bus_arbiter;

    logic        clock = 1'b0;
    logic        resetN;
    logic [1:0]  req, lock, reqWrite;
    logic [23:0] reqAddr;
    logic [15:0] reqWdata;
    logic [1:0]  grant, ack;
    logic [7:0]  rdata;
    logic        busy, memValid, memWrite;
    logic [11:0] memAddr;
    logic [7:0]  memWdata, memRdata;

    logic [11:0] a_arr [2];
    logic [7:0]  d_arr [2];
    assign reqAddr  = {a_arr[1], a_arr[0]};
    assign reqWdata = {d_arr[1], d_arr[0]};

    mem_bus_arbiter #(
        .REQUESTERS(2), .ADDR_WIDTH(12), .DATA_WIDTH(8), .MAX_HOLD(4)
    ) dut (
        .clock(clock), .resetN(resetN), .req(req), .lock(lock), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqWdata(reqWdata), .grant(grant), .ack(ack), .rdata(rdata),
        .busy(busy), .memValid(memValid), .memWrite(memWrite), .memAddr(memAddr),
        .memWdata(memWdata), .memRdata(memRdata)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] pat(input logic [11:0] a);
        return (a == 12'h0A5) ? 8'h3C : (a[7:0] ^ 8'h5A);
    endfunction

    function automatic logic [1:0] onehot(input int m);
        return (m == 0) ? 2'b01 : 2'b10;
    endfunction

    // Memory model: contents preset to pat(), reads combinational on memAddr.
    logic [7:0] mem [4096];
    logic       mem_ready = 1'b0;
    assign memRdata = mem[memAddr];
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(12'(i));
            mem_ready <= 1'b1;
        end else if (memValid && memWrite) begin
            mem[memAddr] <= memWdata;
        end
    end

    typedef struct {
        int         m;
        logic       wr;
        logic [11:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        int         gap;
    } acc_t;

    acc_t       exp_q[$];
    acc_t       tbl [6];
    acc_t       pend;
    bit         pend_v = 1'b0;
    bit         mon_en = 1'b0;
    int         cyc = 0, last_cyc = 0;
    int         n_checks = 0, n_pass = 0;
    logic [7:0] last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input int m, input logic wr, input logic [11:0] a,
                        input logic [7:0] d, input int gap);
        acc_t e;
        e.m = m; e.wr = wr; e.addr = a; e.wdata = d; e.gap = gap;
        e.rd = wr ? last_rd : pat(a);
        last_rd = e.rd;
        exp_q.push_back(e);
    endtask

    // Scoreboard: each memValid pops an expected access; the following cycle must carry its ack.
    always @(negedge clock) begin
        cyc++;
        if (!mon_en) begin
            pend_v = 1'b0;
        end else begin
            chk("ack_onehot", 32'($onehot0(ack)), 32'd1);
            chk("grant_onehot", 32'($onehot0(grant)), 32'd1);
            if (pend_v) begin
                chk("ack", 32'(ack), 32'(onehot(pend.m)));
                chk("rdata", 32'(rdata), 32'(pend.rd));
                chk("busy_ack", 32'(busy), 32'd1);
                pend_v = 1'b0;
            end else begin
                chk("no_stray_ack", 32'(ack), 32'd0);
            end
            if (memValid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access_addr", 32'(memAddr), 32'hFFFF_FFFF);
                end else begin
                    pend = exp_q.pop_front();
                    chk("grant", 32'(grant), 32'(onehot(pend.m)));
                    chk("memWrite", 32'(memWrite), 32'(pend.wr));
                    chk("memAddr", 32'(memAddr), 32'(pend.addr));
                    if (pend.wr) chk("memWdata", 32'(memWdata), 32'(pend.wdata));
                    chk("busy_issue", 32'(busy), 32'd1);
                    if (pend.gap != 0) chk("access_gap", 32'(cyc - last_cyc), 32'(pend.gap));
                    last_cyc = cyc;
                    pend_v   = 1'b1;
                end
            end
        end
    end

    task automatic run_master(input int m, input int n, input logic [11:0] abase,
                              input logic wr, input logic [7:0] dbase,
                              input logic lk, input int delay);
        int t;
        repeat (delay) @(negedge clock);
        for (int j = 0; j < n; j++) begin
            a_arr[m]    = abase + 12'(j);
            d_arr[m]    = dbase + 8'(j);
            reqWrite[m] = wr;
            lock[m]     = lk;
            req[m]      = 1'b1;
            t = 0;
            do begin
                @(negedge clock);
                t++;
            end while (!ack[m] && t < 40);
            chk("ack_seen", 32'(ack[m]), 32'd1);
        end
        req[m]  = 1'b0;
        lock[m] = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_memValid"}, 32'(memValid), 32'd0);
        chk({tag, "_memWrite"}, 32'(memWrite), 32'd0);
        chk({tag, "_memAddr"}, 32'(memAddr), 32'd0);
        chk({tag, "_memWdata"}, 32'(memWdata), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || pend_v) && t < 60) begin
            @(negedge clock);
            t++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        mon_en = 1'b0;
        resetN = 1'b0;
        #1 check_idle("rst_pulse");
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        last_rd = 8'h00;
        mon_en  = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; req = '0; lock = '0; reqWrite = '0;
        a_arr[0] = '0; a_arr[1] = '0; d_arr[0] = '0; d_arr[1] = '0;
        last_rd = 8'h00;

        tbl[0] = '{0, 1'b0, 12'h0A5, 8'h00, 8'h3C, 0};
        tbl[1] = '{1, 1'b1, 12'hFFF, 8'h7E, 8'h3C, 0};
        tbl[2] = '{1, 1'b0, 12'hFFF, 8'h00, 8'h7E, 0};
        tbl[3] = '{0, 1'b1, 12'h000, 8'h11, 8'h7E, 0};
        tbl[4] = '{0, 1'b0, 12'h000, 8'h00, 8'h11, 0};
        tbl[5] = '{1, 1'b0, 12'h123, 8'h00, 8'h79, 0};

        repeat (3) @(negedge clock);
        check_idle("reset");
        resetN = 1'b1;
        @(negedge clock);

        // Reset asserted while master 0's read is in ISSUE aborts it without an ack.
        a_arr[0] = 12'h123; reqWrite[0] = 1'b0; req[0] = 1'b1;
        @(negedge clock);
        chk("mid_memValid", 32'(memValid), 32'd1);
        chk("mid_memAddr", 32'(memAddr), 32'h123);
        resetN = 1'b0; req[0] = 1'b0;
        #1 check_idle("rst_mid");
        @(negedge clock);
        chk("rst_mid_noack", 32'(ack), 32'd0);
        resetN = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_ack", 32'(ack), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_grant", 32'(grant), 32'd0);
        end
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(tbl[i]);
            last_rd = tbl[i].rd;
            run_master(tbl[i].m, 1, tbl[i].addr, tbl[i].wr, tbl[i].wdata, 1'b0, 0);
            repeat (2) @(negedge clock);
            drain();
        end

        // Early drop: request withdrawn right after it is sampled still completes once.
        push(0, 1'b0, 12'h0A5, 8'h00, 0);
        a_arr[0] = 12'h0A5; reqWrite[0] = 1'b0; req[0] = 1'b1;
        @(negedge clock);
        req[0] = 1'b0;
        repeat (5) @(negedge clock);
        chk("drop_grant", 32'(grant), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        drain();

        // Contention from reset: rotation starts at master 0 and alternates every 3 cycles.
        pulse_reset();
        for (int j = 0; j < 3; j++) begin
            push(0, 1'b0, 12'h100 + 12'(j), 8'h00, (j == 0) ? 0 : 3);
            push(1, 1'b1, 12'h200 + 12'(j), 8'hA0 + 8'(j), 3);
        end
        fork
            run_master(0, 3, 12'h100, 1'b0, 8'h00, 1'b0, 0);
            run_master(1, 3, 12'h200, 1'b1, 8'hA0, 1'b0, 0);
        join
        drain();
        chk("mem_written", 32'(mem[12'h202]), 32'hA2);

        // Lock limit: four chained master-1 accesses, then master 0, then master 1 resumes.
        repeat (2) @(negedge clock);
        push(1, 1'b0, 12'h300, 8'h00, 0);
        push(1, 1'b0, 12'h301, 8'h00, 2);
        push(1, 1'b0, 12'h302, 8'h00, 2);
        push(1, 1'b0, 12'h303, 8'h00, 2);
        push(0, 1'b0, 12'h050, 8'h00, 3);
        push(1, 1'b0, 12'h304, 8'h00, 3);
        push(1, 1'b0, 12'h305, 8'h00, 2);
        fork
            run_master(1, 6, 12'h300, 1'b0, 8'h00, 1'b1, 0);
            run_master(0, 1, 12'h050, 1'b0, 8'h00, 1'b0, 1);
        join
        drain();
        repeat (3) @(negedge clock);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_grant", 32'(grant), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
